// File: rtl/nway_cache.sv
// Set-associative write-back cache with per-way LRU ages and a line-wide memory port.
// Requests are looked up the cycle after acceptance; misses write back a dirty victim, refill, then replay.
module nway_cache #(
  parameter int LINE_SIZE = 16,
  parameter int NUM_SETS  = 8,
  parameter int NUM_WAYS  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   is_input_valid,
  input  logic [31:0]            addr,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic [31:0]            din,
  output logic                   is_ready,
  output logic                   is_output_valid,
  output logic [31:0]            dout,
  output logic                   is_hit,
  output logic [31:0]            hit_count,
  output logic [31:0]            miss_count,
  output logic                   dm_is_input_valid,
  output logic [31:0]            dm_addr,
  output logic                   dm_mem_read,
  output logic                   dm_mem_write,
  output logic [8*LINE_SIZE-1:0] dm_din,
  input  logic                   dm_mem_ready,
  input  logic                   dm_is_output_valid,
  input  logic [8*LINE_SIZE-1:0] dm_dout
);
  localparam int OFF_W  = $clog2(LINE_SIZE);
  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int TAG_W  = 32 - OFF_W - IDX_W;
  localparam int WORDS  = LINE_SIZE / 4;
  localparam int WSEL_W = OFF_W - 2;
  localparam int LINE_W = 8 * LINE_SIZE;
  localparam int WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam logic [WAY_W-1:0] AGE_MAX = WAY_W'(NUM_WAYS - 1);
  localparam logic [31:0]      CNT_MAX = '1;

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WB_REQ, S_FILL_REQ, S_FILL_WAIT} state_t;

  state_t            state_q, state_d;
  logic [31:2]       addr_q, addr_d;
  logic [31:0]       din_q, din_d;
  logic              is_store_q, is_store_d;
  logic              refill_q, refill_d;
  logic [WAY_W-1:0]  victim_q, victim_d;
  logic [31:0]       hit_count_q, hit_count_d;
  logic [31:0]       miss_count_q, miss_count_d;

  logic              valid_q [NUM_SETS][NUM_WAYS];
  logic              dirty_q [NUM_SETS][NUM_WAYS];
  logic [WAY_W-1:0]  age_q   [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0]  tag_q   [NUM_SETS][NUM_WAYS];
  logic [LINE_W-1:0] data_q  [NUM_SETS][NUM_WAYS];

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [WSEL_W-1:0] word_sel;
  logic              hit_any, inv_found;
  logic [WAY_W-1:0]  hit_way, vic_way;
  logic [31:0]       hit_word;
  logic              accept, lookup_hit, wb_take, fill_take;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^addr[1:0];
  assign req_tag  = addr_q[31 -: TAG_W];
  assign req_idx  = addr_q[OFF_W +: IDX_W];
  assign word_sel = addr_q[2 +: WSEL_W];

  assign accept     = (state_q == S_IDLE) && is_input_valid && (mem_read || mem_write);
  assign lookup_hit = (state_q == S_LOOKUP) && hit_any;
  assign wb_take    = (state_q == S_WB_REQ) && dm_mem_ready;
  assign fill_take  = (state_q == S_FILL_WAIT) && dm_is_output_valid;

  // Tag match plus victim choice: lowest invalid way first, otherwise the oldest way.
  always_comb begin
    hit_any   = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    vic_way   = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_q[req_idx][w]) begin
        inv_found = 1'b1;
        vic_way   = WAY_W'(w);
      end
    end
    if (!inv_found) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (age_q[req_idx][w] == AGE_MAX) vic_way = WAY_W'(w);
      end
    end
  end

  always_comb begin
    hit_word = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (word_sel == WSEL_W'(i)) hit_word = data_q[req_idx][hit_way][32*i +: 32];
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    din_d        = din_q;
    is_store_d   = is_store_q;
    refill_d     = refill_q;
    victim_d     = victim_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d     = addr[31:2];
          din_d      = din;
          is_store_d = mem_write;
          refill_d   = 1'b0;
          state_d    = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit_any) begin
          state_d = S_IDLE;
          if (!refill_q && (hit_count_q != CNT_MAX)) hit_count_d = hit_count_q + 32'd1;
        end else begin
          if (miss_count_q != CNT_MAX) miss_count_d = miss_count_q + 32'd1;
          victim_d = vic_way;
          state_d  = (valid_q[req_idx][vic_way] && dirty_q[req_idx][vic_way]) ? S_WB_REQ : S_FILL_REQ;
        end
      end
      S_WB_REQ:    if (dm_mem_ready) state_d = S_FILL_REQ;
      S_FILL_REQ:  if (dm_mem_ready) state_d = S_FILL_WAIT;
      S_FILL_WAIT: begin
        if (dm_is_output_valid) begin
          refill_d = 1'b1;
          state_d  = S_LOOKUP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      din_q        <= '0;
      is_store_q   <= 1'b0;
      refill_q     <= 1'b0;
      victim_q     <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
      is_store_q   <= is_store_d;
      refill_q     <= refill_d;
      victim_q     <= victim_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  // A refilled way is parked at the oldest age so its replayed hit shifts every other way down by one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          age_q[s][w]   <= '0;
        end
      end
    end else if (lookup_hit) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (WAY_W'(w) == hit_way) age_q[req_idx][w] <= '0;
        else if (age_q[req_idx][w] < age_q[req_idx][hit_way])
          age_q[req_idx][w] <= age_q[req_idx][w] + WAY_W'(1);
      end
      if (is_store_q) dirty_q[req_idx][hit_way] <= 1'b1;
    end else if (wb_take) begin
      dirty_q[req_idx][victim_q] <= 1'b0;
    end else if (fill_take) begin
      valid_q[req_idx][victim_q] <= 1'b1;
      dirty_q[req_idx][victim_q] <= 1'b0;
      age_q[req_idx][victim_q]   <= AGE_MAX;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_take) begin
      data_q[req_idx][victim_q] <= dm_dout;
      tag_q[req_idx][victim_q]  <= req_tag;
    end else if (lookup_hit && is_store_q) begin
      for (int i = 0; i < WORDS; i++) begin
        if (word_sel == WSEL_W'(i)) data_q[req_idx][hit_way][32*i +: 32] <= din_q;
      end
    end
  end

  assign is_ready          = (state_q == S_IDLE);
  assign is_output_valid   = lookup_hit;
  assign is_hit            = lookup_hit && !refill_q;
  assign dout              = (lookup_hit && !is_store_q) ? hit_word : 32'd0;
  assign hit_count         = hit_count_q;
  assign miss_count        = miss_count_q;
  assign dm_is_input_valid = (state_q == S_WB_REQ) || (state_q == S_FILL_REQ);
  assign dm_mem_write      = (state_q == S_WB_REQ);
  assign dm_mem_read       = (state_q == S_FILL_REQ);

  always_comb begin
    dm_addr = '0;
    dm_din  = '0;
    case (state_q)
      S_WB_REQ: begin
        dm_addr = {tag_q[req_idx][victim_q], req_idx, {OFF_W{1'b0}}};
        dm_din  = data_q[req_idx][victim_q];
      end
      S_FILL_REQ: dm_addr = {req_tag, req_idx, {OFF_W{1'b0}}};
      default: ;
    endcase
  end
endmodule

// File: tb/tb_nway_cache.sv
// Randomised and directed bench for nway_cache against a recency-list cache model and a line memory model.
module tb_nway_cache;
  localparam int LINE_SIZE = 16;
  localparam int NUM_SETS  = 8;
  localparam int NUM_WAYS  = 4;
  localparam int LW        = 8 * LINE_SIZE;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          is_input_valid = 1'b0;
  logic [31:0]   addr = '0;
  logic          mem_read = 1'b0;
  logic          mem_write = 1'b0;
  logic [31:0]   din = '0;
  logic          is_ready, is_output_valid, is_hit;
  logic [31:0]   dout, hit_count, miss_count;
  logic          dm_is_input_valid, dm_mem_read, dm_mem_write;
  logic [31:0]   dm_addr;
  logic [LW-1:0] dm_din;
  logic          dm_mem_ready = 1'b0;
  logic          dm_is_output_valid = 1'b0;
  logic [LW-1:0] dm_dout = '0;

  nway_cache #(.LINE_SIZE(LINE_SIZE), .NUM_SETS(NUM_SETS), .NUM_WAYS(NUM_WAYS)) dut (
    .clk(clk), .reset(reset), .is_input_valid(is_input_valid), .addr(addr),
    .mem_read(mem_read), .mem_write(mem_write), .din(din), .is_ready(is_ready),
    .is_output_valid(is_output_valid), .dout(dout), .is_hit(is_hit),
    .hit_count(hit_count), .miss_count(miss_count), .dm_is_input_valid(dm_is_input_valid),
    .dm_addr(dm_addr), .dm_mem_read(dm_mem_read), .dm_mem_write(dm_mem_write),
    .dm_din(dm_din), .dm_mem_ready(dm_mem_ready), .dm_is_output_valid(dm_is_output_valid),
    .dm_dout(dm_dout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic checkOutput(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: observed %0h, required %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] default_line(input logic [31:0] la);
    logic [LW-1:0] l;
    l = '0;
    for (int w = 0; w < LINE_SIZE / 4; w++) l[32*w +: 32] = la ^ (32'h01010101 * w) ^ 32'hA5000000;
    return l;
  endfunction

  // Memory side: random ready/response latency, optional stray response strobes while no fill is pending.
  logic [LW-1:0] dev_mem [int unsigned];
  bit            pend_fill = 0, hold_fill = 0, spurious_en = 0;
  int            fill_delay = 0;
  logic [31:0]   pend_addr = '0;
  logic [31:0]   wb_addr_log[$];
  logic [LW-1:0] wb_data_log[$];
  logic [31:0]   fill_addr_log[$];

  always @(negedge clk) begin
    dm_mem_ready       = 1'b0;
    dm_is_output_valid = 1'b0;
    dm_dout            = '0;
    if (reset) pend_fill = 0;
    else if (pend_fill) begin
      if (!hold_fill) begin
        if (fill_delay == 0) begin
          dm_is_output_valid = 1'b1;
          dm_dout   = dev_mem.exists(pend_addr) ? dev_mem[pend_addr] : default_line(pend_addr);
          pend_fill = 0;
        end else fill_delay--;
      end
    end else if (dm_is_input_valid) begin
      if ($urandom_range(0, 2) != 0) begin
        dm_mem_ready = 1'b1;
        if (dm_mem_write) begin
          dev_mem[dm_addr] = dm_din;
          wb_addr_log.push_back(dm_addr);
          wb_data_log.push_back(dm_din);
        end else if (dm_mem_read) begin
          pend_fill  = 1;
          pend_addr  = dm_addr;
          fill_delay = $urandom_range(0, 3);
          fill_addr_log.push_back(dm_addr);
        end
      end
    end else if (spurious_en && ($urandom_range(0, 5) == 0)) begin
      dm_is_output_valid = 1'b1;
      dm_dout = {(LINE_SIZE/4){32'hBAD0BAD0}};
    end
  end

  // Reference cache: per set a recency-ordered list of line addresses (front = most recent).
  logic [LW-1:0] ref_mem  [int unsigned];
  logic [LW-1:0] ref_line [int unsigned];
  bit            ref_dirty [int unsigned];
  int unsigned   ref_lru [NUM_SETS][$];
  int unsigned   ref_hits = 0, ref_misses = 0;

  task automatic refReset();
    for (int s = 0; s < NUM_SETS; s++) ref_lru[s].delete();
    ref_line.delete();
    ref_dirty.delete();
    ref_hits   = 0;
    ref_misses = 0;
  endtask

  task automatic refAccess(input logic [31:0] a, input bit is_store, input logic [31:0] d,
                           output bit eh, output logic [31:0] edout, output bit ewb,
                           output logic [31:0] ewa, output logic [LW-1:0] ewl, output logic [31:0] efa);
    int unsigned la, set, word, v;
    int pos;
    logic [LW-1:0] tmp;
    la = a - (a % LINE_SIZE);
    set = (a / LINE_SIZE) % NUM_SETS;
    word = (a % LINE_SIZE) / 4;
    eh = 0; edout = '0; ewb = 0; ewa = '0; ewl = '0; efa = '0;
    pos = -1;
    for (int i = 0; i < ref_lru[set].size(); i++) if (ref_lru[set][i] == la) pos = i;
    if (pos >= 0) begin
      eh = 1;
      ref_hits++;
      ref_lru[set].delete(pos);
    end else begin
      ref_misses++;
      if (ref_lru[set].size() == NUM_WAYS) begin
        v = ref_lru[set].pop_back();
        if (ref_dirty[v]) begin
          ewb = 1; ewa = v; ewl = ref_line[v];
          ref_mem[v] = ref_line[v];
        end
        ref_line.delete(v);
        ref_dirty.delete(v);
      end
      ref_line[la]  = ref_mem.exists(la) ? ref_mem[la] : default_line(la);
      ref_dirty[la] = 0;
      efa = la;
    end
    ref_lru[set].push_front(la);
    tmp = ref_line[la];
    if (is_store) begin
      tmp[32*word +: 32] = d;
      ref_line[la]  = tmp;
      ref_dirty[la] = 1;
    end else edout = tmp[32*word +: 32];
  endtask

  logic          last_hit;
  logic [31:0]   last_dout, last_fill_addr, last_wb_addr;
  logic [LW-1:0] last_wb_line;
  int            last_wb_count, last_dm_count;

  task automatic applyStimulus(input logic [31:0] a, input logic rd, input logic wr, input logic [31:0] d);
    bit eh, ewb, got;
    logic [31:0] edout, ewa, efa;
    logic [LW-1:0] ewl;
    int cyc;
    refAccess(a, wr, d, eh, edout, ewb, ewa, ewl, efa);
    wb_addr_log.delete(); wb_data_log.delete(); fill_addr_log.delete();
    checkOutput("ready", is_ready, 1'b1);
    is_input_valid = 1'b1; addr = a; mem_read = rd; mem_write = wr; din = d;
    @(negedge clk);
    is_input_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    cyc = 1; got = 0;
    while (!got && cyc <= 200) begin
      if (is_output_valid === 1'b1) got = 1;
      else begin @(negedge clk); cyc++; end
    end
    checkOutput("response", got, 1'b1);
    last_hit  = is_hit;
    last_dout = dout;
    checkOutput("is_hit", is_hit, eh);
    if (eh) checkOutput("hit_latency", cyc, 1);
    if (!wr) checkOutput("dout", dout, edout);
    checkOutput("wb_count", wb_addr_log.size(), ewb);
    if (ewb && wb_addr_log.size() > 0) begin
      checkOutput("wb_addr", wb_addr_log[0], ewa);
      checkOutput("wb_line", wb_data_log[0], ewl);
    end
    checkOutput("fill_count", fill_addr_log.size(), !eh);
    if (!eh && fill_addr_log.size() > 0) checkOutput("fill_addr", fill_addr_log[0], efa);
    last_wb_count  = wb_addr_log.size();
    last_dm_count  = wb_addr_log.size() + fill_addr_log.size();
    last_wb_addr   = (wb_addr_log.size() > 0) ? wb_addr_log[0] : 32'hFFFFFFFF;
    last_wb_line   = (wb_data_log.size() > 0) ? wb_data_log[0] : '0;
    last_fill_addr = (fill_addr_log.size() > 0) ? fill_addr_log[0] : 32'hFFFFFFFF;
    @(negedge clk);
    checkOutput("pulse_width", is_output_valid, 1'b0);
    checkOutput("hit_count", hit_count, ref_hits);
    checkOutput("miss_count", miss_count, ref_misses);
  endtask

  task automatic resetDut();
    reset = 1'b1;
    is_input_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk); @(negedge clk);
    checkOutput("rst_ready", is_ready, 1'b1);
    checkOutput("rst_out_valid", is_output_valid, 1'b0);
    checkOutput("rst_dm_valid", dm_is_input_valid, 1'b0);
    checkOutput("rst_hit_count", hit_count, 0);
    checkOutput("rst_miss_count", miss_count, 0);
    reset = 1'b0;
    refReset();
    @(negedge clk);
  endtask

  task automatic ignoredRequest();
    int resp, dm;
    resp = 0; dm = 0;
    is_input_valid = 1'b1; addr = 32'h40; mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    is_input_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (is_output_valid) resp++;
      if (dm_is_input_valid) dm++;
      @(negedge clk);
    end
    checkOutput("ignored_resp", resp, 0);
    checkOutput("ignored_dm", dm, 0);
    checkOutput("ignored_hit_count", hit_count, ref_hits);
    checkOutput("ignored_miss_count", miss_count, ref_misses);
  endtask

  task automatic resetDuringFill();
    int t, resp;
    hold_fill = 1;
    fill_addr_log.delete();
    is_input_valid = 1'b1; addr = 32'h40; mem_read = 1'b1; mem_write = 1'b0;
    @(negedge clk);
    is_input_valid = 1'b0; mem_read = 1'b0;
    t = 0;
    while (fill_addr_log.size() == 0 && t < 50) begin @(negedge clk); t++; end
    checkOutput("fw_fill_issued", fill_addr_log.size(), 1);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    checkOutput("fw_out_valid", is_output_valid, 1'b0);
    checkOutput("fw_dout", dout, 0);
    checkOutput("fw_is_hit", is_hit, 1'b0);
    checkOutput("fw_dm_valid", dm_is_input_valid, 1'b0);
    checkOutput("fw_dm_read", dm_mem_read, 1'b0);
    checkOutput("fw_dm_addr", dm_addr, 0);
    checkOutput("fw_ready", is_ready, 1'b1);
    checkOutput("fw_miss_count", miss_count, 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0; hold_fill = 0;
    refReset();
    resp = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (is_output_valid) resp++;
    end
    checkOutput("fw_no_response", resp, 0);
    applyStimulus(32'h40, 1'b1, 1'b0, 32'h0);
    checkOutput("fw_reload_is_hit", last_hit, 1'b0);
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [LW-1:0] l40;
    logic [31:0] ra;
    int op;
    l40 = default_line(32'h40);
    l40[31:0] = 32'h11111111;
    dev_mem[32'h40] = l40;
    ref_mem[32'h40] = l40;
    resetDut();

    applyStimulus(32'h40, 1'b1, 1'b0, 32'h0);
    checkOutput("s1_fill_addr", last_fill_addr, 32'h40);
    checkOutput("s1_dout", last_dout, 32'h11111111);
    checkOutput("s1_is_hit", last_hit, 1'b0);
    checkOutput("s1_miss_count", miss_count, 1);
    applyStimulus(32'h40, 1'b1, 1'b0, 32'h0);
    checkOutput("s1_rehit", last_hit, 1'b1);
    checkOutput("s1_hit_count", hit_count, 1);
    applyStimulus(32'h44, 1'b0, 1'b1, 32'hDEADBEEF);
    checkOutput("s2_no_dm", last_dm_count, 0);
    applyStimulus(32'h44, 1'b1, 1'b0, 32'h0);
    checkOutput("s2_dout", last_dout, 32'hDEADBEEF);

    resetDut();
    for (int i = 0; i < 4; i++) applyStimulus(32'h80 * i, 1'b0, 1'b1, 32'hC0DE0000 + i);
    applyStimulus(32'h200, 1'b1, 1'b0, 32'h0);
    checkOutput("s3_wb_addr", last_wb_addr, 32'h0);
    checkOutput("s3_wb_word0", last_wb_line[31:0], 32'hC0DE0000);
    checkOutput("s3_fill_addr", last_fill_addr, 32'h200);

    resetDut();
    applyStimulus(32'h000, 1'b1, 1'b0, 32'h0);
    applyStimulus(32'h080, 1'b1, 1'b0, 32'h0);
    applyStimulus(32'h100, 1'b1, 1'b0, 32'h0);
    applyStimulus(32'h180, 1'b1, 1'b0, 32'h0);
    applyStimulus(32'h000, 1'b1, 1'b0, 32'h0);
    applyStimulus(32'h200, 1'b1, 1'b0, 32'h0);
    checkOutput("s4_no_wb", last_wb_count, 0);
    applyStimulus(32'h000, 1'b1, 1'b0, 32'h0);
    checkOutput("s4_kept_hit", last_hit, 1'b1);

    applyStimulus(32'h008, 1'b1, 1'b1, 32'h5A5A5A5A);
    applyStimulus(32'h008, 1'b1, 1'b0, 32'h0);
    checkOutput("s5_both_is_store", last_dout, 32'h5A5A5A5A);
    ignoredRequest();

    resetDut();
    resetDuringFill();

    resetDut();
    spurious_en = 1;
    for (int n = 0; n < 150; n++) begin
      ra = ($urandom_range(0, 5) << 7) | ($urandom_range(0, 1) << 4) | ($urandom_range(0, 3) << 2);
      op = $urandom_range(0, 3);
      case (op)
        0, 1:    applyStimulus(ra, 1'b1, 1'b0, 32'h0);
        2:       applyStimulus(ra, 1'b0, 1'b1, $urandom());
        default: applyStimulus(ra, 1'b1, 1'b1, $urandom());
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/nway_cache.md
NWAY_CACHE -- requirements
Module: nway_cache

Interface
REQ-001 Parameter LINE_SIZE, default 16, line size in bytes (power of two, >=8).
REQ-002 Parameter NUM_SETS, default 8, number of sets (power of two, >=2).
REQ-003 Parameter NUM_WAYS, default 4, associativity (power of two, 1..8).
REQ-004 Port list, in order:
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- is_input_valid  in  1  CPU request valid.
- addr  in  32  byte address, word-aligned.
- mem_read  in  1  load request.
- mem_write  in  1  store request.
- din  in  32  store data.
- is_ready  out  1  cache can accept a request this cycle.
- is_output_valid  out  1  one-cycle response strobe.
- dout  out  32  load data, valid with is_output_valid.
- is_hit  out  1  response was a first-lookup hit, valid with is_output_valid.
- hit_count  out  32  saturating hit counter.
- miss_count  out  32  saturating miss counter.
- dm_is_input_valid  out  1  memory request strobe.
- dm_addr  out  32  line-aligned memory address.
- dm_mem_read  out  1  memory read.
- dm_mem_write  out  1  memory write.
- dm_din  out  8*LINE_SIZE  write-back line.
- dm_mem_ready  in  1  memory accepts a request.
- dm_is_output_valid  in  1  fill line valid.
- dm_dout  in  8*LINE_SIZE  fill line.

Function
REQ-005 Address split: offset = log2(LINE_SIZE) LSBs; index = next log2(NUM_SETS) bits; tag = remaining MSBs; word select = addr[log2(LINE_SIZE)-1:2]; word w occupies line bits [32w+31:32w].
REQ-006 Per way per set, the cache SHALL hold valid, dirty, tag, line data, and an LRU age of log2(NUM_WAYS) bits.
REQ-007 States: IDLE, LOOKUP, WB_REQ, FILL_REQ, FILL_WAIT.
REQ-008 is_ready SHALL be 1 only in IDLE; a request is accepted when is_input_valid & is_ready & (mem_read | mem_write), and addr/din/op are registered on acceptance.
REQ-009 mem_write=1 with mem_read=1 SHALL be a store; a valid request with both low SHALL be ignored.
REQ-010 LOOKUP, hit: response in the same cycle (accept cycle N -> is_output_valid at N+1); load drives the selected word on dout; store writes din into the word, sets dirty; hit way age becomes 0 and ways younger than it increment by 1; next state IDLE.
REQ-011 LOOKUP, miss: victim = lowest-index invalid way, else the way with age NUM_WAYS-1; next state WB_REQ if victim valid and dirty, else FILL_REQ.
REQ-012 WB_REQ: drive dm_is_input_valid=1, dm_mem_write=1, dm_addr={victim tag, index, zero offset}, dm_din=victim line; when dm_mem_ready=1, clear victim dirty and go to FILL_REQ.
REQ-013 FILL_REQ: drive dm_is_input_valid=1, dm_mem_read=1, dm_addr={req tag, index, zero offset}; when dm_mem_ready=1, go to FILL_WAIT.
REQ-014 FILL_WAIT: on dm_is_output_valid=1, write dm_dout to the victim, set valid=1, dirty=0, tag=req tag; return to LOOKUP; the forced hit completes per REQ-010, but is_hit SHALL be 0 for that response.
REQ-015 dm_is_input_valid, dm_mem_read and dm_mem_write SHALL be 0 outside WB_REQ/FILL_REQ; is_output_valid SHALL be a single-cycle pulse per accepted request.
REQ-016 hit_count SHALL increment on each response with is_hit=1; miss_count SHALL increment once per miss, in the LOOKUP cycle that detects it; both saturate at 0xFFFFFFFF.
REQ-017 Memory responses arriving outside FILL_WAIT SHALL be ignored.

Reset
REQ-018 Reset assertion SHALL immediately force state IDLE, and SHALL clear all valid, dirty, age and counters; is_output_valid, is_hit, dout and all dm_* outputs SHALL be 0, and is_ready SHALL be 1.
REQ-019 Reset mid-operation (any state) SHALL abandon the request with no response; tag/data contents need not be cleared.

Verification
REQ-020 Reset, then load 0x00000040, memory line word0=0x11111111 -> FILL_REQ with dm_addr=0x00000040; response dout=0x11111111, is_hit=0, miss_count=1; repeat the load -> response one cycle after accept, is_hit=1, hit_count=1.
REQ-021 Store 0xDEADBEEF to 0x00000044 after REQ-020 -> hit, no dm traffic; a load from 0x44 returns 0xDEADBEEF.
REQ-022 Defaults: stores to 0x000, 0x080, 0x100, 0x180, then a load 0x200 -> WB_REQ with dm_addr=0x000 and stored data, then FILL_REQ with dm_addr=0x200.
REQ-023 Loads 0x000, 0x080, 0x100, 0x180, 0x000, then 0x200 -> 0x080 is evicted, with no write-back; a following load 0x000 has is_hit=1.
REQ-024 Assert reset during FILL_WAIT -> outputs 0 before the next edge and no response; after release, load 0x040 -> is_hit=0.
REQ-025 Request with mem_read=mem_write=1 -> treated as a store; request with both low -> no response, counters unchanged.
